// File: rtl/led_pio_out.sv
// led_pio_out
// Avalon-MM output PIO driving the board LEDs. Holds a software-written
// output register with atomic set/clear access. An optional timed one-shot
// pulse engine, built when the macro LED_PIO_PULSE_EN is defined, ORs
// status-blink pulses onto the output.
//
// Ports:
//   clk        system clock (single domain)
//   reset      synchronous, active-high reset
//   address    word address: 0 DATA, 1 PULSE_LEN, 2 TICK_DIV, 3 PULSE,
//              4 OUTSET, 5 OUTCLEAR, 6-7 reserved
//   chipselect slave select
//   write_n    active-low write strobe (write = chipselect && !write_n)
//   writedata  write data; bits above the register width are ignored
//   readdata   registered read data (1-cycle latency), zero-extended
//   out_port   LED drive: data_reg | pulse_mask
//
// Bus handshake: there is no wait-state; a write is accepted on every
// clock edge where chipselect is high and write_n is low, and readdata is
// re-registered from address on every edge regardless of chipselect.
//
// Optional feature macro: LED_PIO_PULSE_EN
module led_pio_out #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd1;
    localparam logic [2:0] ADDR_TICK_DIV  = 3'd2;
    localparam logic [2:0] ADDR_PULSE     = 3'd3;
    localparam logic [2:0] ADDR_OUTSET    = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;

    logic             wr_en;
    logic [WIDTH-1:0] wr_val;
    logic [WIDTH-1:0] data_reg;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign wr_en  = chipselect && !write_n;
    assign wr_val = writedata[WIDTH-1:0];
    // Not every writedata bit feeds a register in every build.
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg <= RESET_VALUE;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:     data_reg <= wr_val;
                ADDR_OUTSET:   data_reg <= data_reg | wr_val;
                ADDR_OUTCLEAR: data_reg <= data_reg & ~wr_val;
                default:       data_reg <= data_reg;
            endcase
        end
    end

`ifdef LED_PIO_PULSE_EN
    typedef enum logic {
        PULSE_IDLE   = 1'b0,
        PULSE_ACTIVE = 1'b1
    } pulse_state_t;

    logic [15:0]      pulse_len;
    logic [15:0]      tick_div;
    logic [15:0]      prescaler;
    logic [15:0]      remain;
    logic [WIDTH-1:0] pulse_mask;
    logic [15:0]      prescaler_nxt;
    logic [15:0]      remain_nxt;
    logic [WIDTH-1:0] pulse_mask_nxt;
    logic             trigger;
    pulse_state_t     pulse_state;

    // The engine is active exactly while any pulse bit is lit.
    assign pulse_state = (pulse_mask != '0) ? PULSE_ACTIVE : PULSE_IDLE;

    assign trigger = wr_en && (address == ADDR_PULSE) &&
                     (wr_val != '0) && (pulse_len != 16'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_len <= 16'd0;
            tick_div  <= 16'd0;
        end else if (wr_en) begin
            if (address == ADDR_PULSE_LEN) pulse_len <= writedata[15:0];
            if (address == ADDR_TICK_DIV)  tick_div  <= writedata[15:0];
        end
    end

    always_comb begin
        pulse_mask_nxt = pulse_mask;
        remain_nxt     = remain;
        prescaler_nxt  = prescaler;
        if (pulse_state == PULSE_ACTIVE) begin
            if (prescaler == 16'd0) begin
                // Tick: reload from the live TICK_DIV value.
                prescaler_nxt = tick_div;
                if (remain <= 16'd1) begin
                    remain_nxt     = 16'd0;
                    pulse_mask_nxt = '0;
                end else begin
                    remain_nxt = remain - 16'd1;
                end
            end else begin
                prescaler_nxt = prescaler - 16'd1;
            end
        end
        // A trigger overrides the countdown. If it lands on the expiry
        // edge the mask was already cleared above, so only the new bits
        // survive; otherwise the new bits OR into the running pulse.
        if (trigger) begin
            pulse_mask_nxt = pulse_mask_nxt | wr_val;
            remain_nxt     = pulse_len;
            prescaler_nxt  = tick_div;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_mask <= '0;
            remain     <= 16'd0;
            prescaler  <= 16'd0;
        end else begin
            pulse_mask <= pulse_mask_nxt;
            remain     <= remain_nxt;
            prescaler  <= prescaler_nxt;
        end
    end

    assign out_port = data_reg | pulse_mask;

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:      rd_mux[WIDTH-1:0] = data_reg;
            ADDR_PULSE_LEN: rd_mux[15:0]      = pulse_len;
            ADDR_TICK_DIV:  rd_mux[15:0]      = tick_div;
            ADDR_PULSE:     rd_mux[WIDTH-1:0] = pulse_mask;
            default:        rd_mux            = '0;
        endcase
    end
`else
    assign out_port = data_reg;

    always_comb begin
        rd_mux = '0;
        if (address == ADDR_DATA) rd_mux[WIDTH-1:0] = data_reg;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) readdata <= 32'd0;
        else       readdata <= rd_mux;
    end

endmodule

// File: tb/tb_led_pio_out.sv
module tb_led_pio_out;

    localparam int         WIDTH   = 4;
    localparam logic [3:0] RST_VAL = 4'h9;
`ifdef LED_PIO_PULSE_EN
    localparam bit pulse_on = 1'b1;
`else
    localparam bit pulse_on = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  out_port;

    int n_cmp;
    int n_bad;
    logic [WIDTH-1:0] exp_q[$];

    led_pio_out #(.WIDTH(WIDTH), .RESET_VALUE(RST_VAL)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // drivers: inputs change mid-cycle, outputs checked #1 after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a);
        @(negedge clk);
        address = a;
        @(posedge clk);
        #1;
    endtask

    task automatic check_trace(input string tag);
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        check_val(tag, {28'd0, out_port}, {28'd0, e});
    endtask

    initial begin
        int hi3;
        n_cmp      = 0;
        n_bad      = 0;
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        repeat (3) step();
        check_val("reset_out", {28'd0, out_port}, 32'h9);
        check_val("reset_rd", readdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        bus_read(3'd3);
        check_val("rd_pulse_reset", readdata, 32'h0);

        // DATA register
        bus_write(3'd0, 32'h5);
        check_val("data_wr", {28'd0, out_port}, 32'h5);
        bus_read(3'd0);
        check_val("data_rd", readdata, 32'h5);
        bus_write(3'd0, 32'hFFF0);
        check_val("data_upper_drop", {28'd0, out_port}, 32'h0);
        bus_read(3'd0);
        check_val("data_upper_rd", readdata, 32'h0);

        // OUTSET / OUTCLEAR
        bus_write(3'd0, 32'h5);
        bus_write(3'd4, 32'h2);
        check_val("outset", {28'd0, out_port}, 32'h7);
        bus_write(3'd5, 32'h1);
        check_val("outclear", {28'd0, out_port}, 32'h6);
        bus_read(3'd4);
        check_val("rd_outset", readdata, 32'h0);
        bus_read(3'd5);
        check_val("rd_outclear", readdata, 32'h0);
        bus_write(3'd6, 32'hF);
        check_val("reserved_wr", {28'd0, out_port}, 32'h6);
        bus_read(3'd7);
        check_val("rd_reserved", readdata, 32'h0);
        bus_write(3'd0, 32'h0);

        // configuration registers
        bus_write(3'd2, 32'h3);
        bus_write(3'd1, 32'h2);
        bus_read(3'd1);
        check_val("rd_pulse_len", readdata, pulse_on ? 32'h2 : 32'h0);
        bus_read(3'd2);
        check_val("rd_tick_div", readdata, pulse_on ? 32'h3 : 32'h0);

        // single pulse: 2 ticks x 4 clocks = 8 clocks high
        for (int k = 0; k < 12; k++)
            exp_q.push_back((pulse_on && k < 8) ? 4'h8 : 4'h0);
        bus_write(3'd3, 32'h8);
        check_trace("pulse1_k0");
        for (int k = 1; k < 12; k++) begin
            step();
            check_trace($sformatf("pulse1_k%0d", k));
            if (k == 4) check_val("rd_mask_active", readdata, pulse_on ? 32'h8 : 32'h0);
            if (k == 10) check_val("rd_mask_idle", readdata, 32'h0);
        end

        // retrigger at clock 5 with bit 0
        for (int k = 0; k < 16; k++)
            exp_q.push_back(!pulse_on ? 4'h0 : (k < 5) ? 4'h8 : (k < 13) ? 4'h9 : 4'h0);
        hi3 = 0;
        bus_write(3'd3, 32'h8);
        if (out_port[3]) hi3++;
        check_trace("retrig_k0");
        for (int k = 1; k < 16; k++) begin
            if (k == 5) bus_write(3'd3, 32'h1);
            else        step();
            if (out_port[3]) hi3++;
            check_trace($sformatf("retrig_k%0d", k));
        end
        check_val("retrig_bit3_len", hi3, pulse_on ? 32'd13 : 32'd0);

        // PULSE_LEN = 0: trigger ignored
        bus_write(3'd1, 32'h0);
        bus_write(3'd3, 32'hF);
        check_val("len0_out", {28'd0, out_port}, 32'h0);
        step();
        check_val("len0_out2", {28'd0, out_port}, 32'h0);
        bus_read(3'd3);
        check_val("len0_mask", readdata, 32'h0);

        // reset during a long pulse
        bus_write(3'd1, 32'd100);
        bus_write(3'd3, 32'h2);
        repeat (9) step();
        check_val("long_pulse", {28'd0, out_port}, pulse_on ? 32'h2 : 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step();
        check_val("reset_mid_pulse", {28'd0, out_port}, 32'h9);
        @(negedge clk);
        reset = 1'b0;
        bus_read(3'd3);
        check_val("mask_after_reset", readdata, 32'h0);
        bus_read(3'd1);
        check_val("len_after_reset", readdata, 32'h0);
        step();
        check_val("out_after_reset", {28'd0, out_port}, 32'h9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_pio_out.md
# led_pio_out

Avalon-MM output PIO for the board LEDs. It pairs with the switch input PIO on the same Qsys interconnect: that block samples inputs, this one drives outputs. It holds a software-written output register with atomic set/clear access, plus an optional timed one-shot pulse engine for status blinks. Output is `out_port = data_reg | pulse_mask`.

## Interface
Parameters:
- `WIDTH`, 4: number of output bits (1..32).
- `RESET_VALUE`, 0: value loaded into `data_reg` on reset.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `address`  in  3  register select.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe; a write occurs when `chipselect && !write_n`.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data, zero-extended.
- `out_port`  out  WIDTH  LED drive.

## Operation
Register map (word addresses):
- 0 DATA, R/W: `data_reg[WIDTH-1:0]`.
- 1 PULSE_LEN, R/W: `[15:0]`, pulse length in ticks.
- 2 TICK_DIV, R/W: `[15:0]`; one tick every TICK_DIV+1 clocks.
- 3 PULSE, W: bits set in `writedata` start pulses on those bits. Read returns `pulse_mask`.
- 4 OUTSET, W: `data_reg |= writedata`. Reads 0.
- 5 OUTCLEAR, W: `data_reg &= ~writedata`. Reads 0.
- 6 and 7: reserved. Read 0; writes ignored.

Write rules:
- Unused upper `writedata` bits are ignored.

Pulse engine:
- State is IDLE (`pulse_mask == 0`) or ACTIVE.
- Trigger with a nonzero WIDTH-masked value and PULSE_LEN ≠ 0:
  - `pulse_mask |= value`.
  - `remain <= PULSE_LEN`.
  - Prescaler restarts at TICK_DIV.
- Trigger with PULSE_LEN = 0 or a zero value: ignored.
- In ACTIVE, each clock the prescaler decrements. At 0 it reloads from the current TICK_DIV and issues a tick.
- Each tick decrements `remain`. The tick that takes `remain` from 1 to 0 clears `pulse_mask` (ACTIVE→IDLE) in the same edge.
- Retrigger while ACTIVE: new bits OR in, and the counter and prescaler reload. All active bits are extended together, since the counter is shared.
- Writes to PULSE_LEN during ACTIVE take effect at the next trigger. Writes to TICK_DIV take effect at the next prescaler reload.
- DATA, OUTSET and OUTCLEAR writes never alter `pulse_mask`.

## Timing
- Reset values:
  - `data_reg = RESET_VALUE`, so `out_port = RESET_VALUE`.
  - PULSE_LEN = 0, TICK_DIV = 0.
  - `pulse_mask = 0`, prescaler = 0, remain = 0.
  - `readdata = 0`.
- Reset mid-pulse: pulse aborts and `pulse_mask` is 0 on the next edge.
- Write → `out_port` change: 1 clock; visible after the edge that samples the write.
- Read:
  - `readdata` is registered every clock from `address`, regardless of `chipselect`, giving 1-cycle read latency.
  - A read in the cycle after a write returns the new value.
- Pulse duration: exactly PULSE_LEN × (TICK_DIV+1) clocks of `out_port` high. Counted from the first cycle after the trigger write (assuming `data_reg` bit = 0).
- Trigger on the same edge as expiry: the trigger wins. Mask = new bits only, plus any re-triggered bits, with counters reloaded.

## Configuration
- `LED_PIO_PULSE_EN` defined: the pulse engine, PULSE_LEN, TICK_DIV and PULSE are present as above.
- Not defined:
  - Addresses 1–3 read 0 and ignore writes.
  - No counters are synthesized.
  - `out_port = data_reg`.
  - DATA, OUTSET and OUTCLEAR are unchanged.

## Test plan
- Reset with RESET_VALUE = 4'h9 → `out_port` = 4'h9 and `readdata` = 0. Read addr 3 (pulse build) → 0.
- Write DATA = 0x5 → `out_port` = 4'h5 one clock later. Read addr 0 → `readdata` = 0x5 after 1 clock. Write 0xFFF0 → `out_port` = 4'h0 (upper bits dropped).
- From DATA = 0x5: OUTSET 0x2 → 0x7, then OUTCLEAR 0x1 → 0x6. Reads of addr 4 and 5 → 0.
- TICK_DIV = 3, PULSE_LEN = 2, PULSE write 0x8 with DATA = 0:
  - `out_port[3]` is high for exactly 8 clocks, then low.
  - Addr 3 reads 0x8 during the pulse and 0 after.
- Same setup, PULSE 0x8, then PULSE 0x1 at clock 5:
  - Bits 3 and 0 are both high for 8 clocks from the second trigger.
  - Total high time for bit 3 is 13 clocks.
- PULSE_LEN = 0 then PULSE 0xF → no change on `out_port`. A pulse started with PULSE_LEN = 100 and `reset` asserted at clock 10 → `out_port` = RESET_VALUE next clock. With the macro undefined, PULSE writes have no effect.
